// File: rtl/sel_sequencer.sv
// rtl/sel_sequencer.sv - dwell-timed select-code sequencer (0..LAST_CODE, wraps) for the partial-case mux stage
// Optional feature macro: SEL_SEQ_DIR_EN adds a dir input for down-counting.
module sel_sequencer #(
  parameter int SEL_W     = 2,
  parameter int DWELL_W   = 8,
  parameter int LAST_CODE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
`ifdef SEL_SEQ_DIR_EN
  input  logic               dir,
`endif
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [SEL_W-1:0]   load_sel,
  output logic [SEL_W-1:0]   sel,
  output logic               step,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_CODE);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt, w_sel_adv;
  logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_step, w_step_nxt;
  logic                 r_wrap, w_wrap_nxt, w_wrap_adv;
  logic                 w_dir;

`ifdef SEL_SEQ_DIR_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  always_comb begin
    if (w_dir) begin
      w_wrap_adv = (r_sel == '0);
      w_sel_adv  = w_wrap_adv ? LAST : r_sel - SEL_W'(1);
    end else begin
      w_wrap_adv = (r_sel == LAST);
      w_sel_adv  = w_wrap_adv ? '0 : r_sel + SEL_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_sel_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (load) begin
      w_sel_nxt = (load_sel > LAST) ? LAST : load_sel;
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (en) w_state_nxt = S_RUN;
        end
        // A resuming PAUSE counts on the same edge, so the retained cnt carries straight on.
        S_RUN, S_PAUSE: begin
          if (!en) begin
            w_state_nxt = S_PAUSE;
          end else begin
            w_state_nxt = S_RUN;
            if (r_cnt >= dwell) begin
              w_sel_nxt  = w_sel_adv;
              w_cnt_nxt  = '0;
              w_step_nxt = 1'b1;
              w_wrap_nxt = w_wrap_adv;
            end else begin
              w_cnt_nxt = r_cnt + DWELL_W'(1);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign sel  = r_sel;
  assign step = r_step;
  assign wrap = r_wrap;
  assign busy = (r_state == S_RUN);

endmodule
